// File: rtl/mdr_mem_ctrl.sv
// -----------------------------------------------------------------------------
// mdr_mem_ctrl
//
// Sequences one memory read or write on behalf of the control unit and drives
// the MDR load and transfer controls that go with it.
//
// Read sequence:  IDLE -> RD_WAIT (mem_rd, wait for mem_ready) -> RD_XFER -> DONE
// Write sequence: IDLE -> WR_LOAD (MDR <- Z) -> WR_WAIT (mem_wr) -> DONE
// If mem_ready does not arrive in time, the access aborts through ERR.
//
// Parameters
//   TIMEOUT     wait-state cycles allowed before an access aborts (1..255)
//
// Ports
//   clk         rising-edge system clock
//   rst_n       asynchronous active-low reset
//   rd_req      read request (level, held until done)
//   wr_req      write request (level, held until done)
//   mar_addr    access address from MAR, sampled in IDLE
//   mem_ready   memory access-complete strobe
//   mem_addr    latched access address to memory
//   mem_rd      memory read strobe
//   mem_wr      memory write strobe
//   ld_mdr_mem  load MDR from the memory data bus
//   ld_mdr_z    load MDR from the Z bus
//   t_mdr_mem   drive MDR onto the memory data bus
//   t_mdr_x     drive MDR onto the X bus
//   busy        access in progress
//   done        one-cycle completion pulse (also on abort)
//   err         one-cycle timeout-abort pulse
// -----------------------------------------------------------------------------
module mdr_mem_ctrl #(
    parameter int unsigned TIMEOUT = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rd_req,
    input  logic        wr_req,
    input  logic [15:0] mar_addr,
    input  logic        mem_ready,
    output logic [15:0] mem_addr,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic        ld_mdr_mem,
    output logic        ld_mdr_z,
    output logic        t_mdr_mem,
    output logic        t_mdr_x,
    output logic        busy,
    output logic        done,
    output logic        err
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RD_WAIT = 3'd1,
        S_RD_XFER = 3'd2,
        S_WR_LOAD = 3'd3,
        S_WR_WAIT = 3'd4,
        S_DONE    = 3'd5,
        S_ERR     = 3'd6
    } state_t;

    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    state_t      state_q, state_d;
    logic [7:0]  wait_cnt_q, wait_cnt_d;
    logic [15:0] mem_addr_q, mem_addr_d;

    // State register, wait counter and address latch
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            wait_cnt_q <= 8'd0;
            mem_addr_q <= 16'h0000;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            mem_addr_q <= mem_addr_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        mem_addr_d = mem_addr_q;
        case (state_q)
            S_IDLE: begin
                // Read has priority when both requests arrive together
                if (rd_req) begin
                    mem_addr_d = mar_addr;
                    wait_cnt_d = 8'd0;
                    state_d    = S_RD_WAIT;
                end else if (wr_req) begin
                    mem_addr_d = mar_addr;
                    state_d    = S_WR_LOAD;
                end
            end
            S_RD_WAIT: begin
                // A ready strobe on the last allowed cycle still completes
                if (mem_ready) begin
                    state_d = S_RD_XFER;
                end else if (wait_cnt_q == TIMEOUT_CNT) begin
                    state_d = S_ERR;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end
            S_RD_XFER: state_d = S_DONE;
            S_WR_LOAD: begin
                wait_cnt_d = 8'd0;
                state_d    = S_WR_WAIT;
            end
            S_WR_WAIT: begin
                if (mem_ready) begin
                    state_d = S_DONE;
                end else if (wait_cnt_q == TIMEOUT_CNT) begin
                    state_d = S_ERR;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output decode: everything is Moore except ld_mdr_mem, which must
    // capture the data bus in the very cycle memory signals ready.
    always_comb begin
        mem_rd     = 1'b0;
        mem_wr     = 1'b0;
        ld_mdr_mem = 1'b0;
        ld_mdr_z   = 1'b0;
        t_mdr_mem  = 1'b0;
        t_mdr_x    = 1'b0;
        busy       = (state_q != S_IDLE);
        done       = 1'b0;
        err        = 1'b0;
        case (state_q)
            S_RD_WAIT: begin
                mem_rd     = 1'b1;
                ld_mdr_mem = mem_ready;
            end
            S_RD_XFER: t_mdr_x = 1'b1;
            S_WR_LOAD: ld_mdr_z = 1'b1;
            S_WR_WAIT: begin
                mem_wr    = 1'b1;
                t_mdr_mem = 1'b1;
            end
            S_DONE: done = 1'b1;
            S_ERR: begin
                done = 1'b1;
                err  = 1'b1;
            end
            default: ;
        endcase
    end

    assign mem_addr = mem_addr_q;

endmodule

// File: tb/tb_mdr_mem_ctrl.sv
module tb_mdr_mem_ctrl;

    localparam int T = 8;

    // Output vector bit weights: {busy,mem_rd,mem_wr,ld_mdr_mem,ld_mdr_z,t_mdr_mem,t_mdr_x,done,err}
    localparam logic [8:0] V_BUSY  = 9'b1_0000_0000;
    localparam logic [8:0] V_RD    = 9'b0_1000_0000;
    localparam logic [8:0] V_WR    = 9'b0_0100_0000;
    localparam logic [8:0] V_LDMEM = 9'b0_0010_0000;
    localparam logic [8:0] V_LDZ   = 9'b0_0001_0000;
    localparam logic [8:0] V_TMEM  = 9'b0_0000_1000;
    localparam logic [8:0] V_TX    = 9'b0_0000_0100;
    localparam logic [8:0] V_DONE  = 9'b0_0000_0010;
    localparam logic [8:0] V_ERR   = 9'b0_0000_0001;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rd_req, wr_req, mem_ready;
    logic [15:0] mar_addr, mem_addr;
    logic        mem_rd, mem_wr, ld_mdr_mem, ld_mdr_z, t_mdr_mem, t_mdr_x;
    logic        busy, done, err;
    logic [8:0]  obs_vec;

    int checks = 0;
    int failures = 0;
    logic [15:0] last_addr;

    mdr_mem_ctrl #(.TIMEOUT(T)) dut (
        .clk(clk), .rst_n(rst_n), .rd_req(rd_req), .wr_req(wr_req),
        .mar_addr(mar_addr), .mem_ready(mem_ready), .mem_addr(mem_addr),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .ld_mdr_mem(ld_mdr_mem),
        .ld_mdr_z(ld_mdr_z), .t_mdr_mem(t_mdr_mem), .t_mdr_x(t_mdr_x),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    assign obs_vec = {busy, mem_rd, mem_wr, ld_mdr_mem, ld_mdr_z, t_mdr_mem, t_mdr_x, done, err};

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Idle cycles: no request, random noise on mem_ready and mar_addr.
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            rd_req    = 1'b0;
            wr_req    = 1'b0;
            mem_ready = 1'($urandom_range(0, 1));
            mar_addr  = 16'($urandom);
            #1;
            chk("idle_outputs", 32'(obs_vec), 32'(9'd0));
            chk("idle_addr_hold", 32'(mem_addr), 32'(last_addr));
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    // One access. d = number of wait cycles that pass without mem_ready
    // before the strobe; d > T means memory never answers.
    // Entered and left just after a falling edge.
    task automatic run_txn(input string name, input bit rd, input bit wr,
                           input logic [15:0] addr, input int d);
        logic [8:0] exp_q[$];
        bit         rdy_q[$];
        bit         fixed_q[$];
        bit         is_rd;
        bit         timed_out;
        int         waits;
        is_rd     = rd;
        timed_out = (d > T);
        waits     = timed_out ? T + 1 : d + 1;

        // Expected phase list derived from the access protocol
        exp_q.push_back(9'd0);  rdy_q.push_back(1'b0); fixed_q.push_back(1'b0);
        if (!is_rd) begin
            exp_q.push_back(V_BUSY | V_LDZ); rdy_q.push_back(1'b0); fixed_q.push_back(1'b0);
        end
        for (int k = 1; k <= waits; k++) begin
            bit strobe;
            strobe = !timed_out && (k == waits);
            if (is_rd)
                exp_q.push_back(V_BUSY | V_RD | (strobe ? V_LDMEM : 9'd0));
            else
                exp_q.push_back(V_BUSY | V_WR | V_TMEM);
            rdy_q.push_back(strobe);
            fixed_q.push_back(1'b1);
        end
        if (timed_out) begin
            exp_q.push_back(V_BUSY | V_DONE | V_ERR); rdy_q.push_back(1'b0); fixed_q.push_back(1'b0);
        end else begin
            if (is_rd) begin
                exp_q.push_back(V_BUSY | V_TX); rdy_q.push_back(1'b0); fixed_q.push_back(1'b0);
            end
            exp_q.push_back(V_BUSY | V_DONE); rdy_q.push_back(1'b0); fixed_q.push_back(1'b0);
        end

        for (int c = 0; c < exp_q.size(); c++) begin
            rd_req    = rd;
            wr_req    = wr;
            mar_addr  = (c == 0) ? addr : 16'($urandom);
            mem_ready = fixed_q[c] ? rdy_q[c] : 1'($urandom_range(0, 1));
            #1;
            chk($sformatf("%s_c%0d_outputs", name, c), 32'(obs_vec), 32'(exp_q[c]));
            chk($sformatf("%s_c%0d_addr", name, c), 32'(mem_addr),
                32'((c == 0) ? last_addr : addr));
            @(posedge clk);
            @(negedge clk);
        end
        last_addr = addr;
        $display("txn %s rd=%0d wr=%0d addr=%h delay=%0d cycles=%0d timeout=%0d",
                 name, rd, wr, addr, d, exp_q.size(), timed_out);
    endtask

    initial begin
        rst_n     = 1'b0;
        rd_req    = 1'b0;
        wr_req    = 1'b0;
        mem_ready = 1'b0;
        mar_addr  = 16'h5555;
        last_addr = 16'h0000;
        #3;
        chk("reset_outputs", 32'(obs_vec), 32'(9'd0));
        chk("reset_addr", 32'(mem_addr), 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);

        // Directed accesses
        run_txn("read_1234", 1'b1, 1'b0, 16'h1234, 2);
        idle(1);
        run_txn("write_00ff", 1'b0, 1'b1, 16'h00FF, 0);
        idle(1);
        run_txn("both_read", 1'b1, 1'b1, 16'hC0DE, 1);
        run_txn("both_write", 1'b0, 1'b1, 16'hC0DE, 1);
        idle(1);
        run_txn("rd_timeout", 1'b1, 1'b0, 16'h0BAD, 99);
        idle(1);
        run_txn("wr_timeout", 1'b0, 1'b1, 16'h0BAE, 99);
        idle(1);
        run_txn("rd_boundary", 1'b1, 1'b0, 16'h7777, T);
        run_txn("wr_boundary", 1'b0, 1'b1, 16'h8888, T);
        idle(1);

        // Reset in the middle of a write wait state
        wr_req    = 1'b1;
        mar_addr  = 16'hBEEF;
        mem_ready = 1'b0;
        @(posedge clk); @(negedge clk);   // WR_LOAD
        @(posedge clk); @(negedge clk);   // WR_WAIT
        #1;
        chk("rst_pre_wr_wait", 32'(obs_vec), 32'(V_BUSY | V_WR | V_TMEM));
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst_async_outputs", 32'(obs_vec), 32'(9'd0));
        chk("rst_async_addr", 32'(mem_addr), 32'h0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            mem_ready = 1'($urandom_range(0, 1));
            #1;
            chk("rst_held_no_done", 32'(obs_vec), 32'(9'd0));
        end
        @(negedge clk);
        rst_n     = 1'b1;
        last_addr = 16'h0000;
        run_txn("after_reset", 1'b1, 1'b0, 16'hA5A5, 1);
        idle(1);

        // Randomized accesses
        for (int n = 0; n < 40; n++) begin
            int kind;
            int d;
            logic [15:0] a;
            kind = $urandom_range(0, 2);
            d    = $urandom_range(0, T + 2);
            a    = 16'($urandom);
            if (kind == 0) begin
                run_txn($sformatf("rnd%0d_rd", n), 1'b1, 1'b0, a, d);
            end else if (kind == 1) begin
                run_txn($sformatf("rnd%0d_wr", n), 1'b0, 1'b1, a, d);
            end else begin
                run_txn($sformatf("rnd%0d_both_rd", n), 1'b1, 1'b1, a, d);
                run_txn($sformatf("rnd%0d_both_wr", n), 1'b0, 1'b1, a,
                        $urandom_range(0, T + 2));
            end
            idle($urandom_range(0, 2));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Absolute time guard so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog_timeout observed=running expected=finished");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/mdr_mem_ctrl.md
MDR_MEM_CTRL -- requirements
Module: mdr_mem_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 8: maximum wait-state cycles allowed for mem_ready before an access aborts (legal 1..255).
REQ-002 SHALL have port clk  input  1  rising-edge system clock.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port rd_req  input  1  control-unit memory read request, level, held until done.
REQ-005 SHALL have port wr_req  input  1  control-unit memory write request, level, held until done.
REQ-006 SHALL have port mar_addr  input  16  access address from MAR.
REQ-007 SHALL have port mem_ready  input  1  memory access-complete strobe.
REQ-008 SHALL have port mem_addr  output  16  latched access address to memory.
REQ-009 SHALL have ports mem_rd and mem_wr  output  1 each  memory read and write strobes.
REQ-010 SHALL have ports ld_mdr_mem, ld_mdr_z, t_mdr_mem, t_mdr_x  output  1 each  MDR load and transfer controls.
REQ-011 SHALL have ports busy, done, err  output  1 each  access in progress, completion pulse, timeout-abort pulse.

Function
REQ-012 SHALL implement states IDLE, RD_WAIT, RD_XFER, WR_LOAD, WR_WAIT, DONE, ERR, with state held in a register.
REQ-013 SHALL, in IDLE with rd_req=1, latch mar_addr into mem_addr and go to RD_WAIT; rd_req wins if wr_req=1 in the same cycle, and wr_req is ignored until the next IDLE.
REQ-014 SHALL, in IDLE with wr_req=1 and rd_req=0, latch mar_addr and go to WR_LOAD.
REQ-015 SHALL assert ld_mdr_z for exactly one cycle in WR_LOAD, then go to WR_WAIT.
REQ-016 SHALL drive mem_wr=1 and t_mdr_mem=1 throughout WR_WAIT and go to DONE on the first cycle with mem_ready=1.
REQ-017 SHALL drive mem_rd=1 throughout RD_WAIT and assert ld_mdr_mem=1 combinationally in RD_WAIT only in the cycle where mem_ready=1; that cycle goes to RD_XFER.
REQ-018 SHALL assert t_mdr_x for exactly one cycle in RD_XFER, then go to DONE.
REQ-019 SHALL assert done for exactly one cycle in DONE, then return to IDLE; busy SHALL be 1 in every state except IDLE.
REQ-020 SHALL clear an 8-bit wait counter on entry to RD_WAIT or WR_WAIT and increment it each cycle spent there without mem_ready.
REQ-021 SHALL go to ERR when the wait counter equals TIMEOUT and mem_ready=0; mem_ready=1 in that same cycle SHALL take priority and complete normally.
REQ-022 SHALL assert err and done together for exactly one cycle in ERR with no MDR load or transfer, then return to IDLE.
REQ-023 SHALL decode all outputs except ld_mdr_mem from the state register only (Moore outputs).
REQ-024 SHALL hold mem_addr at its last latched value outside an access.
REQ-025 SHALL ignore mem_ready outside RD_WAIT and WR_WAIT.
REQ-026 SHALL never assert mem_rd and mem_wr together, and never assert ld_mdr_mem and ld_mdr_z together.
REQ-027 SHALL ignore changes to mar_addr after the IDLE cycle in which it was latched.

Reset
REQ-028 SHALL, while rst_n=0 and regardless of clk, force state to IDLE, mem_addr to 0x0000, the wait counter to 0, and every 1-bit output to 0.
REQ-029 SHALL abort any in-flight access on reset with no done or err pulse, and accept a new request on the first clock edge after rst_n rises.

Verification
REQ-030 SHALL cover this read: rd_req=1, mar_addr=0x1234, mem_ready high on the 3rd RD_WAIT cycle -> mem_addr=0x1234, mem_rd high 3 cycles, ld_mdr_mem for 1 cycle, then t_mdr_x for 1 cycle, then done for 1 cycle; total 6 cycles from request to IDLE.
REQ-031 SHALL cover this write: wr_req=1, mar_addr=0x00FF, mem_ready in the 1st WR_WAIT cycle -> ld_mdr_z 1 cycle, mem_wr/t_mdr_mem 1 cycle, done 1 cycle.
REQ-032 SHALL cover simultaneous requests: rd_req=wr_req=1 at IDLE -> a read sequence only; the write starts at the next IDLE if wr_req is still high.
REQ-033 SHALL cover timeout with TIMEOUT=8 and mem_ready held low -> ERR after 9 RD_WAIT cycles, err=done=1 for 1 cycle, no ld_mdr_mem.
REQ-034 SHALL cover the boundary case with TIMEOUT=8 and mem_ready=1 exactly when the counter equals 8 -> normal completion, err stays 0.
REQ-035 SHALL cover reset mid-operation: rst_n low during WR_WAIT -> mem_wr, t_mdr_mem and busy drop to 0 immediately, mem_addr=0x0000, and no done pulse.
